// File: rtl/adc_spi_controller.sv
// adc_spi_controller
// SPI master for the stereo audio ADC feeding the equalizer. After one
// priming frame it waits for sample_tick, then runs a two-frame burst that
// reads left and right, and presents both as a 16-bit pair with a one-cycle
// sample_valid strobe.
//
// Configuration macro: ADC_CTRL_OFFSET_CONV_EN
//   defined   -> MSB inverted on capture (offset binary to two's complement 1.15)
//   undefined -> raw offset-binary ADC words
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              level, keeps the ADC session running
//   sample_tick         one-cycle request for an L/R pair
//   adc_sck/sdi/cs_     SPI clock (idles low), command MSB first, chip select
//   adc_sdo             ADC data, MSB first
//   left/right_sample   last sample pair
//   sample_valid        one-cycle pulse when the pair updates
//   busy                high while a frame is being shifted
//   overrun             sticky: a tick arrived while a transfer was in flight
module adc_spi_controller #(
  parameter int          SCK_HALF = 4,
  parameter logic [15:0] CMD_L    = 16'h8000,
  parameter logic [15:0] CMD_R    = 16'hC000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_tick,
  output logic        adc_sck,
  output logic        adc_sdi,
  output logic        adc_cs_,
  input  logic        adc_sdo,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int DW = $clog2(SCK_HALF);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, PRIME, WAIT, FRAME_A, FRAME_B, DONE, STOP
  } state_t;

  state_t        state_reg;
  logic [DW-1:0] div_reg;
  logic [3:0]    bit_reg;
  logic [15:0]   cmd_reg;      // remaining command bits, next one at [15]
  logic [15:0]   rx_reg;       // SDO shift register for the current frame
  logic [15:0]   left_raw_reg; // left word held until the pair is complete

  function automatic logic [15:0] conv(input logic [15:0] raw);
`ifdef ADC_CTRL_OFFSET_CONV_EN
    return {~raw[15], raw[14:0]};
`else
    return raw;
`endif
  endfunction

  logic in_transfer;
  assign in_transfer = (state_reg == PRIME) || (state_reg == FRAME_A) ||
                       (state_reg == FRAME_B) || (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      cmd_reg      <= '0;
      rx_reg       <= '0;
      left_raw_reg <= '0;
      adc_sck      <= 1'b0;
      adc_sdi      <= 1'b0;
      adc_cs_      <= 1'b1;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && in_transfer) overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= PRIME;
            adc_cs_   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            div_reg   <= '0;
            bit_reg   <= '0;
            adc_sck   <= 1'b0;
            adc_sdi   <= CMD_L[15];
            cmd_reg   <= {CMD_L[14:0], 1'b0};
          end
        end

        PRIME, FRAME_A, FRAME_B: begin
          if (div_reg != DIV_LAST) begin
            div_reg <= div_reg + 1'b1;
          end else begin
            div_reg <= '0;
            if (!adc_sck) begin
              // Rising SCK: the ADC's data bit is taken on this same edge.
              adc_sck <= 1'b1;
              rx_reg  <= {rx_reg[14:0], adc_sdo};
            end else if (bit_reg != 4'd15) begin
              adc_sck <= 1'b0;
              bit_reg <= bit_reg + 4'd1;
              adc_sdi <= cmd_reg[15];
              cmd_reg <= {cmd_reg[14:0], 1'b0};
            end else begin
              // End of the last high phase; the next frame (if any) starts
              // its first low phase right away with no gap.
              adc_sck <= 1'b0;
              bit_reg <= '0;
              case (state_reg)
                PRIME: begin
                  state_reg <= WAIT;
                  adc_sdi   <= 1'b0;
                  busy      <= 1'b0;
                end
                FRAME_A: begin
                  state_reg    <= FRAME_B;
                  left_raw_reg <= rx_reg;
                  adc_sdi      <= CMD_L[15];
                  cmd_reg      <= {CMD_L[14:0], 1'b0};
                end
                default: begin // FRAME_B
                  state_reg    <= DONE;
                  adc_sdi      <= 1'b0;
                  busy         <= 1'b0;
                  left_sample  <= conv(left_raw_reg);
                  right_sample <= conv(rx_reg);
                  sample_valid <= 1'b1;
                end
              endcase
            end
          end
        end

        WAIT: begin
          if (!enable) begin
            state_reg <= STOP;
            adc_cs_   <= 1'b1;
          end else if (sample_tick) begin
            // Right command goes out now; the left data it overlaps was
            // selected by the previous frame's CMD_L.
            state_reg <= FRAME_A;
            busy      <= 1'b1;
            div_reg   <= '0;
            bit_reg   <= '0;
            adc_sck   <= 1'b0;
            adc_sdi   <= CMD_R[15];
            cmd_reg   <= {CMD_R[14:0], 1'b0};
          end
        end

        DONE:    state_reg <= WAIT;
        STOP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
